// File: rtl/bnw_game_pkg.sv
// Shared types and widths for the beat game flow controller.
package bnw_game_pkg;

  localparam int unsigned BEAT_W = 7;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StCountdown = 3'd1,
    StPlay      = 3'd2,
    StPause     = 3'd3,
    StDone      = 3'd4
  } state_t;

endpackage

// File: rtl/beat_sync.sv
// Brings the beat counter into the clk domain, filters unstable samples and flags a
// LAST_BEAT -> 0 transition of the accepted value as a one-cycle wrap pulse.
module beat_sync
  import bnw_game_pkg::*;
#(
  parameter logic [BEAT_W-1:0] LAST_BEAT = 7'd96
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BEAT_W-1:0] beat_cnt,
  input  logic              clr,
  output logic              beat_wrap
);

  logic [BEAT_W-1:0] r_sync1;
  logic [BEAT_W-1:0] r_sync2;
  logic [BEAT_W-1:0] r_prev;
  logic [BEAT_W-1:0] r_acc;
  logic              r_wrap;
  logic              w_accept;

  // Bits may cross on different edges; only a value seen twice in a row is trusted.
  assign w_accept = (r_sync2 == r_prev);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_acc   <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_sync1 <= beat_cnt;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (clr) begin
        r_acc  <= '0;
        r_wrap <= 1'b0;
      end else begin
        r_wrap <= w_accept && (r_acc == LAST_BEAT) && (r_sync2 == '0);
        if (w_accept) begin
          r_acc <= r_sync2;
        end
      end
    end
  end

  assign beat_wrap = r_wrap;

endmodule

// File: rtl/beat_sequencer.sv
// Game-flow controller: countdown, play/pause, loop counting and song-end detection,
// driving stop/restart of the beat counter from one-pulse player buttons.
module beat_sequencer
  import bnw_game_pkg::*;
#(
  parameter logic [BEAT_W-1:0] LAST_BEAT = 7'd96,
  parameter int unsigned       CD_STEPS  = 3,
  parameter int unsigned       CD_TICKS  = 50_000_000,
  parameter int unsigned       LOOPS     = 1,
  parameter int unsigned       RST_HOLD  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_start,
  input  logic              btn_pause,
  input  logic              btn_reset,
  input  logic [BEAT_W-1:0] beat_cnt,
  output logic              stop,
  output logic              restart,
  output logic [2:0]        state,
  output logic [1:0]        countdown,
  output logic              song_done,
  output logic [3:0]        loop_cnt
);

  localparam int unsigned PRE_W  = (CD_TICKS > 1) ? $clog2(CD_TICKS) : 1;
  localparam int unsigned HOLD_W = $clog2(RST_HOLD + 1);

  state_t              r_state, w_state_d;
  logic [PRE_W-1:0]    r_pre, w_pre_d;
  logic [HOLD_W-1:0]   r_hold, w_hold_d;
  logic [1:0]          r_countdown, w_cd_d;
  logic [3:0]          r_loop, w_loop_d, w_loop_inc;
  logic                r_stop, r_restart, r_song_done;
  logic                w_start, w_pause, w_tick, w_rst_req, w_wrap;

  beat_sync #(
    .LAST_BEAT(LAST_BEAT)
  ) u_beat_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .beat_cnt (beat_cnt),
    .clr      (r_restart),
    .beat_wrap(w_wrap)
  );

  // Priority: reset > pause > start; dropped pulses are simply masked.
  assign w_pause    = btn_pause & ~btn_reset;
  assign w_start    = btn_start & ~btn_pause & ~btn_reset;
  assign w_tick     = (r_pre == PRE_W'(CD_TICKS - 1));
  assign w_loop_inc = r_loop + 4'd1;

  always_comb begin
    w_state_d = r_state;
    w_pre_d   = r_pre;
    w_cd_d    = r_countdown;
    w_loop_d  = r_loop;
    w_rst_req = 1'b0;
    if (btn_reset) begin
      w_state_d = StIdle;
      w_pre_d   = '0;
      w_cd_d    = 2'd0;
      w_loop_d  = 4'd0;
      w_rst_req = 1'b1;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          if (w_start) begin
            w_state_d = StCountdown;
            w_pre_d   = '0;
            w_cd_d    = 2'(CD_STEPS);
            w_loop_d  = 4'd0;
            w_rst_req = 1'b1;
          end
        end
        StCountdown: begin
          if (w_tick) begin
            w_pre_d = '0;
            if (r_countdown == 2'd1) begin
              w_state_d = StPlay;
              w_cd_d    = 2'd0;
            end else begin
              w_cd_d = r_countdown - 2'd1;
            end
          end else begin
            w_pre_d = r_pre + PRE_W'(1);
          end
        end
        StPlay: begin
          // A wrap coinciding with pause is counted first; completing the run wins.
          if (w_wrap) begin
            w_loop_d = w_loop_inc;
          end
          if (w_wrap && (w_loop_inc == 4'(LOOPS))) begin
            w_state_d = StDone;
          end else if (w_pause) begin
            w_state_d = StPause;
          end
        end
        StPause: begin
          if (w_pause) begin
            w_state_d = StPlay;
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    w_hold_d = r_hold;
    if (w_rst_req) begin
      w_hold_d = HOLD_W'(RST_HOLD);
    end else if (r_hold != '0) begin
      w_hold_d = r_hold - HOLD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_pre       <= '0;
      r_hold      <= '0;
      r_countdown <= 2'd0;
      r_loop      <= 4'd0;
      r_stop      <= 1'b1;
      r_restart   <= 1'b0;
      r_song_done <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_pre       <= w_pre_d;
      r_hold      <= w_hold_d;
      r_countdown <= w_cd_d;
      r_loop      <= w_loop_d;
      r_stop      <= (w_state_d != StPlay);
      r_restart   <= (w_hold_d != '0);
      r_song_done <= (w_state_d == StDone);
    end
  end

  assign stop      = r_stop;
  assign restart   = r_restart;
  assign state     = r_state;
  assign countdown = r_countdown;
  assign song_done = r_song_done;
  assign loop_cnt  = r_loop;

endmodule
